ysyx_23060191_isram: RTL and testbench

Instruction-memory responder for the fetch interface: the memory-side counterpart of the IFU. Accepts one fetch request at a time over a valid/ready handshake, returns the addressed 32-bit instruction word after a fixed latency, and flags misaligned or out-of-range fetches. Sits between the IFU and the program image inside the CPU top. A side-band load port lets the bench preload the program.

---
 rtl/ysyx_23060191_isram.sv | 147 ++++++++++++++
 tb/tb_ysyx_23060191_isram.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060191_isram.sv
// ysyx_23060191_isram: instruction-memory responder for the IFU fetch port.
// Takes one fetch at a time over valid/ready and answers after a fixed latency.
// Misaligned or out-of-range fetches return ebreak with resp_err set.
// A side-band load port writes the program image in any state.
// Optional build macro: ISRAM_RAND_DELAY_EN adds 0-3 pseudo-random extra
// wait cycles per fetch, drawn from an 8-bit LFSR.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | ready for a request; req_ready=1 outside reset
// S_WAIT | request latched; latency counter runs down to zero
// S_RESP | resp_valid=1; instruction and error held until resp_ready
module ysyx_23060191_isram #(
    parameter int unsigned DEPTH   = 4096,
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_inst,
    output logic        resp_err,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned CW     = $clog2(LATENCY + 4);
    localparam logic [32:0] SPAN   = 33'(DEPTH) << 2;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   inst_q, inst_d;
    logic          err_q, err_d;

    logic [31:0]   mem [DEPTH];

    logic [31:0]   fetch_off, ld_off;
    logic          fetch_bad, ld_bad;
    logic [AW-1:0] fetch_idx, ld_idx;
    logic [31:0]   rd_word;
    logic [CW-1:0] extra;
    logic          accept;

`ifdef ISRAM_RAND_DELAY_EN
    logic [7:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, free-running every cycle.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    // LFSR register, reseeded on reset so delay sequences are repeatable.
    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= 8'hA5;
        else     lfsr_q <= lfsr_d;
    end

    assign extra = CW'(lfsr_q[1:0]);
`else
    assign extra = '0;
`endif

    // Address checks: addresses below BASE wrap to huge offsets and fail.
    assign fetch_off = addr_q - BASE;
    assign fetch_bad = (addr_q[1:0] != 2'b00) || ({1'b0, fetch_off} >= SPAN);
    assign fetch_idx = fetch_off[AW+1:2];
    assign ld_off    = ld_addr - BASE;
    assign ld_bad    = (ld_addr[1:0] != 2'b00) || ({1'b0, ld_off} >= SPAN);
    assign ld_idx    = ld_off[AW+1:2];

    // A load landing on the same edge as the read must still be visible,
    // so forward it past the array.
    assign rd_word = (ld_en && !ld_bad && (ld_idx == fetch_idx)) ? ld_data : mem[fetch_idx];

    assign req_ready  = (state_q == S_IDLE) && !rst;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_q == S_RESP);
    assign resp_inst  = inst_q;
    assign resp_err   = err_q;

    // Next-state, counter and response-capture logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_WAIT;
                    addr_d  = req_addr;
                    cnt_d   = CW'(LATENCY - 1) + extra;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                    err_d   = fetch_bad;
                    inst_d  = fetch_bad ? EBREAK : rd_word;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_RESP: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control and response registers; reset drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            inst_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
        end
    end

    // Program store; contents survive reset, bad load addresses are dropped.
    always_ff @(posedge clk) begin
        if (ld_en && !ld_bad) mem[ld_idx] <= ld_data;
    end

endmodule

// File: tb/tb_ysyx_23060191_isram.sv
// Bench for ysyx_23060191_isram: instance 0 uses LATENCY=1, instance 1 LATENCY=3.
module tb_ysyx_23060191_isram;
    localparam int          DEPTH  = 4096;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
`ifdef ISRAM_RAND_DELAY_EN
    localparam int EXTRA = 3;
`else
    localparam int EXTRA = 0;
`endif

    typedef struct packed {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    logic        clk, rst;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_addr  [2];
    logic        resp_valid[2];
    logic        resp_ready[2];
    logic [31:0] resp_inst [2];
    logic        resp_err  [2];
    logic        ld_en     [2];
    logic [31:0] ld_addr   [2];
    logic [31:0] ld_data   [2];

    logic [31:0] model [2][DEPTH];
    exp_t        sb0[$];
    exp_t        sb1[$];
    int          lat_a [100];
    int          lat_b [100];
    int          n_checks = 0;
    int          n_errors = 0;

    ysyx_23060191_isram #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(1)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_addr(req_addr[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_inst(resp_inst[0]), .resp_err(resp_err[0]),
        .ld_en(ld_en[0]), .ld_addr(ld_addr[0]), .ld_data(ld_data[0])
    );

    ysyx_23060191_isram #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(3)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_addr(req_addr[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_inst(resp_inst[1]), .resp_err(resp_err[1]),
        .ld_en(ld_en[1]), .ld_addr(ld_addr[1]), .ld_data(ld_data[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic exp_t exp_of(input int d, input logic [31:0] addr);
        logic [31:0] off;
        exp_t e;
        off = addr - BASE;
        if (addr[1:0] != 2'b00 || off >= 32'(DEPTH * 4)) begin
            e.inst = EBREAK;
            e.err  = 1'b1;
        end else begin
            e.inst = model[d][off[13:2]];
            e.err  = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ld(input int d, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] off;
        @(negedge clk);
        ld_en[d]   = 1'b1;
        ld_addr[d] = addr;
        ld_data[d] = data;
        @(posedge clk);
        #1 ld_en[d] = 1'b0;
        off = addr - BASE;
        if (addr[1:0] == 2'b00 && off < 32'(DEPTH * 4)) model[d][off[13:2]] = data;
    endtask

    task automatic issue(input int d, input logic [31:0] addr, input bit push);
        int k;
        @(negedge clk);
        req_valid[d] = 1'b1;
        req_addr[d]  = addr;
        k = 0;
        while (!req_ready[d] && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) chk("req_ready_timeout", 32'(req_ready[d]), 1);
        if (push) begin
            if (d == 0) sb0.push_back(exp_of(d, addr));
            else        sb1.push_back(exp_of(d, addr));
        end
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        req_addr[d]  = $urandom();
    endtask

    task automatic wait_resp(input int d, output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!resp_valid[d] && lat < 20);
        if (!resp_valid[d]) chk("resp_timeout", 32'(resp_valid[d]), 1);
    endtask

    task automatic compare_resp(input int d, output exp_t e);
        int sz;
        sz = (d == 0) ? sb0.size() : sb1.size();
        chk("sb_nonempty", 32'(sz > 0), 1);
        e = '0;
        if (sz > 0) begin
            e = (d == 0) ? sb0.pop_front() : sb1.pop_front();
            chk("resp_inst", resp_inst[d], e.inst);
            chk("resp_err", 32'(resp_err[d]), 32'(e.err));
        end
    endtask

    task automatic release_resp(input int d, input int hold, input exp_t e);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_valid", 32'(resp_valid[d]), 1);
            chk("hold_inst", resp_inst[d], e.inst);
            chk("hold_req_ready", 32'(req_ready[d]), 0);
        end
        resp_ready[d] = 1'b1;
        @(posedge clk);
        #1 resp_ready[d] = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", 32'(req_ready[d]), 1);
        chk("idle_resp_valid", 32'(resp_valid[d]), 0);
    endtask

    task automatic fetch(input int d, input logic [31:0] addr, input int hold, output int lat);
        exp_t e;
        issue(d, addr, 1'b1);
        wait_resp(d, lat);
        chk("latency_in_range", 32'(lat >= lat_of(d) && lat <= lat_of(d) + EXTRA), 1);
        compare_resp(d, e);
        release_resp(d, hold, e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic run_seq(input int pass);
        int lat;
        for (int i = 0; i < 100; i++) begin
            fetch(0, BASE + 32'(4 * (i % 16)), 0, lat);
            if (pass == 0) lat_a[i] = lat;
            else           lat_b[i] = lat;
        end
    endtask

    initial begin
        int   lat;
        exp_t e;
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d]  = 1'b0;
            req_addr[d]   = '0;
            resp_ready[d] = 1'b0;
            ld_en[d]      = 1'b0;
            ld_addr[d]    = '0;
            ld_data[d]    = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready[0]), 0);
        chk("rst_resp_valid", 32'(resp_valid[0]), 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("post_rst_req_ready", 32'(req_ready[d]), 1);
            chk("post_rst_resp_valid", 32'(resp_valid[d]), 0);
            chk("post_rst_resp_inst", resp_inst[d], 0);
            chk("post_rst_resp_err", 32'(resp_err[d]), 0);
        end

        // Program image for instance 0, plus a dropped out-of-range load that
        // would alias onto word 0 if the range check were missing.
        ld(0, BASE, 32'h0000_0413);
        for (int i = 1; i < 16; i++) ld(0, BASE + 32'(4 * i), 32'h1000_0000 + 32'(i * 17));
        ld(0, BASE + 32'h3FFC, 32'hCAFE_F00D);
        ld(0, BASE + 32'h4000, 32'h1111_1111);

        fetch(0, BASE, 0, lat);
        chk("first_fetch_latency", 32'(lat >= 1 && lat <= 1 + EXTRA), 1);
        fetch(0, BASE + 32'h2, 0, lat);
        fetch(0, BASE + 32'h4000, 0, lat);
        fetch(0, 32'h7FFF_FFFC, 0, lat);
        fetch(0, BASE + 32'h3FFC, 0, lat);
        fetch(0, BASE + 32'h8, 1, lat);

        // LATENCY=3 with the response held off for five cycles.
        ld(1, BASE + 32'h40, 32'h00A0_0093);
        fetch(1, BASE + 32'h40, 5, lat);

        // Load during WAIT is seen; load during RESP is not.
        issue(1, BASE + 32'h40, 1'b0);
        ld(1, BASE + 32'h40, 32'hDEAD_BEEF);
        sb1.push_back({32'hDEAD_BEEF, 1'b0});
        wait_resp(1, lat);
        compare_resp(1, e);
        ld(1, BASE + 32'h40, 32'h1234_5678);
        release_resp(1, 2, e);
        fetch(1, BASE + 32'h40, 0, lat);

        // Reset while in WAIT drops the request.
        issue(1, BASE + 32'h40, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        chk("midrst_req_ready", 32'(req_ready[1]), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_after_req_ready", 32'(req_ready[1]), 1);
        chk("midrst_after_resp_inst", resp_inst[1], 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("midrst_no_resp", 32'(resp_valid[1]), 0);
        end
        fetch(1, BASE + 32'h40, 0, lat);
        fetch(1, BASE + 32'h41, 0, lat);

        // Back-to-back fetches, repeated after reset for a reproducible latency trace.
        do_reset();
        run_seq(0);
        do_reset();
        run_seq(1);
        for (int i = 0; i < 100; i++) chk("lat_repeat", 32'(lat_b[i]), 32'(lat_a[i]));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
